// File: rtl/quarter_wave_sincos_rom.sv
// Quarter-wave sine/cosine lookup.
// One quarter period of |sin| is held in a ROM; quadrant symmetry (mirror
// address, negate) rebuilds full-period signed sine and cosine from one phase.
// Three register stages: address/sign, ROM read, sign apply. 'en' freezes
// every stage. The table is sampled at half-LSB offsets, so the mirrored
// address ~a lands exactly on the reflected sample point.
module quarter_wave_sincos_rom #(
  parameter int    WIDTH      = 16,
  parameter int    ADDR_BITS  = 8,
  parameter int    PHASE_BITS = ADDR_BITS + 2,
  parameter string INIT_FILE  = "../bench/sineQuarter.txt"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic [PHASE_BITS-1:0]        phase,
  output logic signed [WIDTH-1:0]      sin_out,
  output logic signed [WIDTH-1:0]      cos_out,
  output logic                         out_valid
);

  localparam int  N         = 2 ** ADDR_BITS;
  localparam int  MAG_W     = WIDTH - 1;
  localparam int  NUM_LANES = 2;  // lane 0 = sine, lane 1 = cosine
  localparam int  STAGES    = 3;
  localparam real PI        = 3.14159265358979323846;

  // The table is generated at elaboration from the same formula the external
  // hex file holds, so the path is kept only for drop-in compatibility.
  localparam string unused_init_file = INIT_FILE;

  // mem[i] = round((2^(WIDTH-1)-1) * sin(pi/2 * (i+0.5)/N))
  function automatic logic [N-1:0][MAG_W-1:0] gen_table();
    logic [N-1:0][MAG_W-1:0] t;
    real amp;
    real x;
    amp = (2.0 ** MAG_W) - 1.0;
    t   = '0;
    for (int i = 0; i < N; i++) begin
      x    = amp * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(N));
      t[i] = MAG_W'($rtoi(x + 0.5));
    end
    return t;
  endfunction

  localparam logic [N-1:0][MAG_W-1:0] ROM = gen_table();

  logic [1:0]                               q;
  logic [ADDR_BITS-1:0]                     a;
  logic [NUM_LANES-1:0][1:0]                quad;
  logic [NUM_LANES-1:0][ADDR_BITS-1:0]      addr_s1;
  logic [NUM_LANES-1:0]                     sgn_s1;
  logic [NUM_LANES-1:0]                     sgn_s2;
  (* rom_style = "block" *)
  logic [NUM_LANES-1:0][MAG_W-1:0]          mag_s2;
  logic [NUM_LANES-1:0][WIDTH-1:0]          samp_s3;
  logic [STAGES:1]                          vld_pipe;

  assign q       = phase[PHASE_BITS-1 -: 2];
  assign a       = phase[ADDR_BITS-1:0];
  assign quad[0] = q;
  assign quad[1] = q + 2'd1;  // cosine leads sine by one quadrant

  // Valid shift register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S1: odd quadrants read the table mirrored; upper quadrants are negative.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        addr_s1[l] <= quad[l][0] ? ~a : a;
        sgn_s1[l]  <= quad[l][1];
      end
    end
  end

  // S2: synchronous ROM read, one port per lane; sign follows alongside.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        mag_s2[l] <= ROM[addr_s1[l]];
        sgn_s2[l] <= sgn_s1[l];
      end
    end
  end

  // S3: apply sign; magnitude <= 2^(WIDTH-1)-1 so negation never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_s3 <= '0;
    end else if (en) begin
      for (int l = 0; l < NUM_LANES; l++)
        samp_s3[l] <= sgn_s2[l] ? -{1'b0, mag_s2[l]} : {1'b0, mag_s2[l]};
    end
  end

  assign sin_out   = samp_s3[0];
  assign cos_out   = samp_s3[1];
  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_quarter_wave_sincos_rom.sv
// Directed bench for quarter_wave_sincos_rom: quadrant points, full sweep
// against a floating-point sine/cosine model, stall, reset, valid bubbles,
// and a reduced-size instance.
module tb_quarter_wave_sincos_rom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, in_valid;
  logic [9:0]         phase;
  logic signed [15:0] sin_out, cos_out;
  logic               out_valid;

  logic               in_valid2;
  logic [7:0]         phase2;
  logic signed [11:0] sin2, cos2;
  logic               out_valid2;

  int checks   = 0;
  int failures = 0;

  int qp[4] = '{0, 256, 512, 768};
  int qs[4] = '{101, 32767, -101, -32767};
  int qc[4] = '{32767, -101, -32767, 101};
  int bv[5] = '{1, 0, 1, 1, 0};
  int cap[64];
  int n, nxt, pp;
  logic e;

  quarter_wave_sincos_rom dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .phase(phase),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
  );

  quarter_wave_sincos_rom #(.WIDTH(12), .ADDR_BITS(6), .INIT_FILE("")) dut12 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid2), .phase(phase2),
    .sin_out(sin2), .cos_out(cos2), .out_valid(out_valid2)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Full-period reference: the half-LSB table offset means every output is
  // amp*sin(2*pi*(p+0.5)/(4N)) rounded half away from zero.
  function automatic int ref_val(input int p, input bit want_cos);
    real amp, th, s;
    amp = 32767.0;
    th  = 2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 1024.0;
    s   = want_cos ? amp * $cos(th) : amp * $sin(th);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  task automatic tick(input logic te, input logic tr, input logic tv, input int tp);
    en = te; rst = tr; in_valid = tv; phase = tp[9:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; phase = '0;
    in_valid2 = 1'b0; phase2 = '0;

    // Reset state
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("rst_sin", sin_out, 0);
    chk("rst_cos", cos_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_valid12", out_valid2, 0);

    // Quadrant points
    for (int k = 0; k < 7; k++) begin
      tick(1, 0, k < 4, (k < 4) ? qp[k] : 0);
      if (k >= 2 && k < 6) begin
        chk("quad_valid", out_valid, 1);
        chk("quad_sin", sin_out, qs[k-2]);
        chk("quad_cos", cos_out, qc[k-2]);
      end else begin
        chk("quad_novalid", out_valid, 0);
      end
    end

    // Full sweep, back-to-back
    tick(1, 1, 0, 0);
    for (int k = 0; k < 1026; k++) begin
      tick(1, 0, k < 1024, k);
      if (k >= 2) begin
        chk("sweep_valid", out_valid, 1);
        chk("sweep_sin", sin_out, ref_val(k - 2, 0));
        chk("sweep_cos", cos_out, ref_val(k - 2, 1));
      end else begin
        chk("sweep_pre", out_valid, 0);
      end
    end

    // Stall: en low for 4 cycles with junk valid input presented
    tick(1, 1, 0, 0);
    n = 0; nxt = 0;
    for (int s = 0; s < 24; s++) begin
      e = !(s >= 8 && s < 12);
      if (e) begin
        pp = nxt; nxt++;
        tick(1, 0, 1, pp);
        cap[n] = pp;
        if (n >= 2) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_sin", sin_out, ref_val(cap[n-2], 0));
          chk("stall_cos", cos_out, ref_val(cap[n-2], 1));
        end else begin
          chk("stall_pre", out_valid, 0);
        end
        n++;
      end else begin
        tick(0, 0, 1, 999);
        chk("hold_valid", out_valid, 1);
        chk("hold_sin", sin_out, ref_val(cap[n-3], 0));
        chk("hold_cos", cos_out, ref_val(cap[n-3], 1));
      end
    end

    // Reset with three samples in flight
    tick(1, 0, 1, 10);
    tick(1, 0, 1, 20);
    tick(1, 1, 1, 30);
    chk("midrst_sin", sin_out, 0);
    chk("midrst_cos", cos_out, 0);
    chk("midrst_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0, 0);
      chk("midrst_flush", out_valid, 0);
    end

    // Reset while stalled
    tick(1, 0, 1, 40);
    tick(1, 0, 1, 50);
    tick(1, 0, 1, 60);
    tick(0, 1, 1, 70);
    chk("enrst_sin", sin_out, 0);
    chk("enrst_cos", cos_out, 0);
    chk("enrst_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 0, 0);
      chk("enrst_flush", out_valid, 0);
    end

    // Valid bubbles 1,0,1,1,0
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, (k < 5) ? bv[k] != 0 : 1'b0, 100 + k);
      if (k >= 2) begin
        chk("bub_valid", out_valid, (k - 2 < 5) ? bv[k-2] : 0);
        if (k - 2 < 5 && bv[k-2] != 0) begin
          chk("bub_sin", sin_out, ref_val(100 + k - 2, 0));
          chk("bub_cos", cos_out, ref_val(100 + k - 2, 1));
        end
      end else begin
        chk("bub_pre", out_valid, 0);
      end
    end

    // Reduced instance: WIDTH=12, ADDR_BITS=6 (mem[0]=25, mem[63]=2047)
    in_valid2 = 1'b1; phase2 = 8'd0;
    tick(1, 0, 0, 0);
    phase2 = 8'd128;
    tick(1, 0, 0, 0);
    in_valid2 = 1'b0; phase2 = 8'd0;
    tick(1, 0, 0, 0);
    chk("w12_valid0", out_valid2, 1);
    chk("w12_sin0", sin2, 25);
    chk("w12_cos0", cos2, 2047);
    tick(1, 0, 0, 0);
    chk("w12_valid128", out_valid2, 1);
    chk("w12_sin128", sin2, -25);
    chk("w12_cos128", cos2, -2047);
    tick(1, 0, 0, 0);
    chk("w12_done", out_valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
